// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding and requester count.
package rr_mux_arbiter_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NREQ = 4;
endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin search: first set request bit starting at ptr, wrapping mod 4.
module rr_priority_pick
  import rr_mux_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [1:0]      win,
  output logic            any
);
  logic [1:0] idx;

  always_comb begin
    win = ptr;
    any = 1'b0;
    idx = ptr;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + 2'(i);
      if (!any && req[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/scale_mux.sv
// Two-input data select used as the building block of the arbiter's 4:1 tree.
module scale_mux #(
  parameter int Size = 8
) (
  input  logic [Size-1:0] a,
  input  logic [Size-1:0] b,
  input  logic            sel,
  output logic [Size-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one registered data path among four requesters,
// holding each grant for up to MaxHold transfers.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int Size    = 8,
  parameter int MaxHold = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [3:0]      REQ,
  input  logic [Size-1:0] DIN0,
  input  logic [Size-1:0] DIN1,
  input  logic [Size-1:0] DIN2,
  input  logic [Size-1:0] DIN3,
  output logic [3:0]      GNT,
  output logic [1:0]      SEL,
  output logic [Size-1:0] OUT,
  output logic            VALID
);
  state_t          state;
  logic [1:0]      ptr;
  logic [7:0]      cnt;
  logic [1:0]      win;
  logic            any;
  logic [Size-1:0] lo_pair;
  logic [Size-1:0] hi_pair;
  logic [Size-1:0] mux_data;

  rr_priority_pick u_pick (
    .req (REQ),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  // Tree is steered by the registered SEL, so data always follows the held grant.
  scale_mux #(.Size(Size)) u_mux_lo (.a(DIN0), .b(DIN1), .sel(SEL[0]), .y(lo_pair));
  scale_mux #(.Size(Size)) u_mux_hi (.a(DIN2), .b(DIN3), .sel(SEL[0]), .y(hi_pair));
  scale_mux #(.Size(Size)) u_mux_out (.a(lo_pair), .b(hi_pair), .sel(SEL[1]), .y(mux_data));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= 2'd0;
      cnt   <= 8'd0;
      GNT   <= 4'd0;
      SEL   <= 2'd0;
      OUT   <= '0;
      VALID <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          VALID <= 1'b0;
          if (any) begin
            GNT   <= 4'b0001 << win;
            SEL   <= win;
            cnt   <= 8'd0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (REQ[SEL]) begin
            OUT   <= mux_data;
            VALID <= 1'b1;
            if (cnt == 8'(MaxHold - 1)) begin
              // Last transfer of the burst; counter parks at zero for the next grant.
              cnt   <= 8'd0;
              GNT   <= 4'd0;
              ptr   <= SEL + 2'd1;
              state <= IDLE;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end else begin
            VALID <= 1'b0;
            GNT   <= 4'd0;
            ptr   <= SEL + 2'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (Size=8, MaxHold=4) with hand-computed expectations.
module tb_rr_mux_arbiter;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] REQ = 4'd0;
  logic [7:0] DIN0 = 8'h00, DIN1 = 8'h00, DIN2 = 8'h00, DIN3 = 8'h00;
  logic [3:0] GNT;
  logic [1:0] SEL;
  logic [7:0] OUT;
  logic       VALID;

  int n_tests = 0;
  int n_fail  = 0;

  rr_mux_arbiter #(.Size(8), .MaxHold(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .DIN0(DIN0), .DIN1(DIN1), .DIN2(DIN2), .DIN3(DIN3),
    .GNT(GNT), .SEL(SEL), .OUT(OUT), .VALID(VALID)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    REQ = 4'd0;
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] g, input logic v);
    check({tag, ".gnt"}, 32'(GNT), 32'(g));
    check({tag, ".valid"}, 32'(VALID), 32'(v));
  endtask

  initial begin
    // Reset values
    do_reset();
    chk_state("rst", 4'd0, 1'b0);
    check("rst.sel", 32'(SEL), 32'd0);
    check("rst.out", 32'(OUT), 32'd0);

    // 1: single requester, three cycles of REQ then drop
    REQ = 4'b0001; DIN0 = 8'hA5;
    step(); chk_state("t1.e1", 4'b0001, 1'b0); check("t1.e1.sel", 32'(SEL), 32'd0);
    step(); chk_state("t1.e2", 4'b0001, 1'b1); check("t1.e2.out", 32'(OUT), 32'hA5);
    step(); chk_state("t1.e3", 4'b0001, 1'b1); check("t1.e3.out", 32'(OUT), 32'hA5);
    REQ = 4'b0000;
    step(); chk_state("t1.e4", 4'b0000, 1'b0); check("t1.e4.out", 32'(OUT), 32'hA5);
    REQ = 4'b0011;  // PTR should now be 1, so requester 1 wins
    step(); chk_state("t1.ptr", 4'b0010, 1'b0); check("t1.ptr.sel", 32'(SEL), 32'd1);
    REQ = 4'b0000;
    step(); chk_state("t1.rel", 4'b0000, 1'b0);

    // 2: all requesting, full bursts in rotation 0,1,2,3,0
    do_reset();
    DIN0 = 8'h10; DIN1 = 8'h11; DIN2 = 8'h12; DIN3 = 8'h13;
    REQ = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      step();
      chk_state($sformatf("t2.g%0d", g), 4'b0001 << (g % 4), 1'b0);
      check($sformatf("t2.g%0d.sel", g), 32'(SEL), 32'(g % 4));
      for (int k = 0; k < 4; k++) begin
        step();
        chk_state($sformatf("t2.g%0d.x%0d", g, k), (k == 3) ? 4'b0000 : (4'b0001 << (g % 4)), 1'b1);
        check($sformatf("t2.g%0d.x%0d.out", g, k), 32'(OUT), 32'h10 + 32'(g % 4));
      end
    end

    // 3: lone requester held -> three bursts of four, re-granted to 0
    do_reset();
    DIN0 = 8'h3C; REQ = 4'b0001;
    for (int b = 0; b < 3; b++) begin
      step();
      chk_state($sformatf("t3.b%0d", b), 4'b0001, 1'b0);
      for (int k = 0; k < 4; k++) begin
        step();
        check($sformatf("t3.b%0d.x%0d.valid", b, k), 32'(VALID), 32'd1);
        check($sformatf("t3.b%0d.x%0d.out", b, k), 32'(OUT), 32'h3C);
      end
    end

    // 4: pointer wrap 3 -> 0
    do_reset();
    DIN0 = 8'hC0; DIN3 = 8'hC3;
    REQ = 4'b0100;
    step(); chk_state("t4.g2", 4'b0100, 1'b0);
    REQ = 4'b0000;
    step(); chk_state("t4.rel2", 4'b0000, 1'b0);
    REQ = 4'b1001;
    step(); chk_state("t4.g3", 4'b1000, 1'b0); check("t4.g3.sel", 32'(SEL), 32'd3);
    step(); chk_state("t4.x3", 4'b1000, 1'b1); check("t4.x3.out", 32'(OUT), 32'hC3);
    REQ = 4'b0001;
    step(); chk_state("t4.rel3", 4'b0000, 1'b0); check("t4.rel3.out", 32'(OUT), 32'hC3);
    step(); chk_state("t4.g0", 4'b0001, 1'b0); check("t4.g0.sel", 32'(SEL), 32'd0);
    REQ = 4'b0000;
    step(); chk_state("t4.rel0", 4'b0000, 1'b0);

    // 5: one-cycle pulse after a prior transfer leaves OUT=77
    do_reset();
    DIN1 = 8'h77; REQ = 4'b0010;
    step(); chk_state("t5.g1", 4'b0010, 1'b0);
    step(); check("t5.x1.out", 32'(OUT), 32'h77);
    REQ = 4'b0000;
    step(); chk_state("t5.rel1", 4'b0000, 1'b0);
    REQ = 4'b0001;
    step(); chk_state("t5.pulse", 4'b0001, 1'b0);
    REQ = 4'b0000;
    step(); chk_state("t5.drop", 4'b0000, 1'b0); check("t5.drop.out", 32'(OUT), 32'h77);
    step(); chk_state("t5.idle", 4'b0000, 1'b0); check("t5.idle.out", 32'(OUT), 32'h77);

    // 6: async reset mid-burst at CNT=2
    do_reset();
    DIN0 = 8'h5A; DIN2 = 8'h22; REQ = 4'b0001;
    step(); step(); step();
    check("t6.pre.out", 32'(OUT), 32'h5A);
    RST = 1'b1;
    #1;
    chk_state("t6.rst", 4'b0000, 1'b0);
    check("t6.rst.sel", 32'(SEL), 32'd0);
    check("t6.rst.out", 32'(OUT), 32'd0);
    RST = 1'b0; REQ = 4'b0100;
    step(); chk_state("t6.g2", 4'b0100, 1'b0); check("t6.g2.sel", 32'(SEL), 32'd2);
    step(); chk_state("t6.x2", 4'b0100, 1'b1); check("t6.x2.out", 32'(OUT), 32'h22);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
